// File: rtl/program_loader.sv
// Loads 16-bit words into instruction memory from byte switches and a debounced push button.
// Optional LOADER_CHECKSUM_EN keeps a running 16-bit sum of written words for the display.
module program_loader #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic                  clk_pi,
   input  logic                  reset_pi,
   input  logic                  clk_en_pi,
   input  logic                  load_mode_pi,
   input  logic [7:0]            byte_pi,
   input  logic                  strobe_pi,
   output logic                  wr_en_po,
   output logic [ADDR_WIDTH-1:0] wr_addr_po,
   output logic [15:0]           wr_data_po,
   output logic                  cpu_hold_po,
   output logic                  cpu_reset_po,
   output logic [ADDR_WIDTH:0]   word_count_po,
   output logic [15:0]           display_num_po
);

   localparam int                  CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0]    DB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [CNT_W-1:0]    DB_ONE   = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   WC_ONE   = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_WRITE,
      S_FULL
   } state_t;

   // ---------------- strobe synchronizer and debouncer ----------------
   logic             strobe_meta_q;
   logic             strobe_sync_q;
   logic             db_level_q, db_level_d;
   logic             db_level_prev_q;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             press;

   always_comb begin
      db_level_d = db_level_q;
      db_cnt_d   = db_cnt_q;
      if (strobe_sync_q == db_level_q) begin
         db_cnt_d = '0;
      end else if (clk_en_pi) begin
         if (db_cnt_q == DB_LAST) begin
            db_level_d = strobe_sync_q;
            db_cnt_d   = '0;
         end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
         end
      end
   end

   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) begin
         strobe_meta_q   <= 1'b0;
         strobe_sync_q   <= 1'b0;
         db_level_q      <= 1'b0;
         db_level_prev_q <= 1'b0;
         db_cnt_q        <= '0;
      end else begin
         strobe_meta_q   <= strobe_pi;
         strobe_sync_q   <= strobe_meta_q;
         db_level_q      <= db_level_d;
         db_level_prev_q <= db_level_q;
         db_cnt_q        <= db_cnt_d;
      end
   end

   // One-cycle pulse in the cycle after the debounced level rises.
   assign press = db_level_q & ~db_level_prev_q;

   // ---------------- load FSM ----------------
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]           wr_data_q, wr_data_d;
   logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
   logic [7:0]            pending_hi_q, pending_hi_d;
   logic                  cpu_reset_q, cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]           checksum_q, checksum_d;
`endif

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      pending_hi_d = pending_hi_q;
      cpu_reset_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (load_mode_pi) begin
               state_d      = S_WAIT_HI;
               wr_addr_d    = '0;
               word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
               checksum_d   = '0;
`endif
            end
         end
         S_WAIT_HI: begin
            if (!load_mode_pi) begin
               state_d     = S_IDLE;
               cpu_reset_d = 1'b1;
            end else if (press) begin
               pending_hi_d = byte_pi;
               state_d      = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            // Leaving mid-word drops the half-captured word.
            if (!load_mode_pi) begin
               state_d      = S_IDLE;
               cpu_reset_d  = 1'b1;
               pending_hi_d = '0;
            end else if (press) begin
               wr_data_d = {pending_hi_q, byte_pi};
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            word_count_d = word_count_q + WC_ONE;
            if (wr_addr_q != ADDR_MAX) begin
               wr_addr_d = wr_addr_q + ADDR_ONE;
            end
`ifdef LOADER_CHECKSUM_EN
            checksum_d = checksum_q + wr_data_q;
`endif
            if (!load_mode_pi) begin
               state_d     = S_IDLE;
               cpu_reset_d = 1'b1;
            end else if (wr_addr_q == ADDR_MAX) begin
               state_d = S_FULL;
            end else begin
               state_d = S_WAIT_HI;
            end
         end
         S_FULL: begin
            if (!load_mode_pi) begin
               state_d     = S_IDLE;
               cpu_reset_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) begin
         state_q      <= S_IDLE;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         word_count_q <= '0;
         pending_hi_q <= '0;
         cpu_reset_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         checksum_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         word_count_q <= word_count_d;
         pending_hi_q <= pending_hi_d;
         cpu_reset_q  <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   // ---------------- outputs ----------------
   assign wr_en_po      = (state_q == S_WRITE);
   assign cpu_hold_po   = (state_q != S_IDLE);
   assign cpu_reset_po  = cpu_reset_q;
   assign wr_addr_po    = wr_addr_q;
   assign wr_data_po    = wr_data_q;
   assign word_count_po = word_count_q;

`ifdef LOADER_CHECKSUM_EN
   assign display_num_po = checksum_q;
`else
   localparam int AXW = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
   logic [AXW-1:0] addr_ext;
   assign addr_ext = AXW'(wr_addr_q);
   // While waiting for the low byte, show where the word will land and its high byte.
   assign display_num_po = (state_q == S_WAIT_LO) ? {addr_ext[7:0], pending_hi_q} : wr_data_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: queue-based write model plus per-cycle write/pulse checks.
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum display.
module tb_program_loader;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_pi;
   logic          clk_en_pi;
   logic          load_mode_pi;
   logic [7:0]    byte_pi;
   logic          strobe_pi;
   logic          wr_en_po;
   logic [AW-1:0] wr_addr_po;
   logic [15:0]   wr_data_po;
   logic          cpu_hold_po;
   logic          cpu_reset_po;
   logic [AW:0]   word_count_po;
   logic [15:0]   display_num_po;

   program_loader #(.ADDR_WIDTH(AW), .DEBOUNCE_TICKS(2)) dut (
      .clk_pi         (clk),
      .reset_pi       (reset_pi),
      .clk_en_pi      (clk_en_pi),
      .load_mode_pi   (load_mode_pi),
      .byte_pi        (byte_pi),
      .strobe_pi      (strobe_pi),
      .wr_en_po       (wr_en_po),
      .wr_addr_po     (wr_addr_po),
      .wr_data_po     (wr_data_po),
      .cpu_hold_po    (cpu_hold_po),
      .cpu_reset_po   (cpu_reset_po),
      .word_count_po  (word_count_po),
      .display_num_po (display_num_po)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   wr_t         exp_q[$];
   int          m_count;
   logic [15:0] m_sum;
   logic [15:0] m_last;
   int          n_exp_writes = 0;

   function automatic int m_addr();
      return (m_count < DEPTH) ? m_count : DEPTH - 1;
   endfunction

   task automatic start_session();
      m_count = 0;
      m_sum   = 16'h0000;
   endtask

   task automatic push_word(input logic [15:0] w);
      wr_t e;
      if (m_count < DEPTH) begin
         e.addr = AW'(m_count);
         e.data = w;
         exp_q.push_back(e);
         n_exp_writes++;
         m_count++;
         m_sum  = m_sum + w;
         m_last = w;
      end
   endtask

   function automatic logic [15:0] m_display();
`ifdef LOADER_CHECKSUM_EN
      return m_sum;
`else
      return m_last;
`endif
   endfunction

   // ---------------- per-cycle compare process ----------------
   int   n_wr_seen   = 0;
   int   n_rst_pulse = 0;
   int   gap         = 100;
   logic prev_wr_en  = 1'b0;
   logic prev_rst    = 1'b0;
   wr_t  got;

   always @(negedge clk) begin
      if (wr_en_po) begin
         n_wr_seen++;
         check("wr_en_single_cycle", {31'd0, prev_wr_en}, 32'd0);
         check("write_gap_ge3", {31'd0, gap >= 3}, 32'd1);
         check("hold_during_write", {31'd0, cpu_hold_po}, 32'd1);
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", {30'd0, wr_addr_po}, 32'hFFFF_FFFF);
         end else begin
            got = exp_q.pop_front();
            check("write_addr", {30'd0, wr_addr_po}, {30'd0, got.addr});
            check("write_data", {16'd0, wr_data_po}, {16'd0, got.data});
`ifndef LOADER_CHECKSUM_EN
            check("display_during_write", {16'd0, display_num_po}, {16'd0, got.data});
`endif
         end
         gap = 0;
      end else begin
         gap++;
      end
      if (cpu_reset_po) begin
         n_rst_pulse++;
         check("cpu_reset_single_cycle", {31'd0, prev_rst}, 32'd0);
         check("hold_low_at_cpu_reset", {31'd0, cpu_hold_po}, 32'd0);
      end
      prev_wr_en = wr_en_po;
      prev_rst   = cpu_reset_po;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_byte(input logic [7:0] b, input int hold);
      byte_pi   = b;
      strobe_pi = 1'b1;
      repeat (hold) tick();
      strobe_pi = 1'b0;
      repeat (8) tick();
   endtask

   task automatic load_word(input logic [7:0] hi, input logic [7:0] lo);
      press_byte(hi, 8);
      push_word({hi, lo});
      press_byte(lo, 8);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_count"}, {29'd0, word_count_po}, 32'(m_count));
      check({tag, "_addr"}, {30'd0, wr_addr_po}, 32'(m_addr()));
      check({tag, "_display"}, {16'd0, display_num_po}, {16'd0, m_display()});
   endtask

   int   rst_snapshot;
   int   wr_snapshot;
   logic seen;

   initial begin
      reset_pi     = 1'b1;
      clk_en_pi    = 1'b1;
      load_mode_pi = 1'b0;
      byte_pi      = 8'h00;
      strobe_pi    = 1'b0;
      m_count      = 0;
      m_sum        = 16'h0000;
      m_last       = 16'h0000;
      repeat (3) tick();
      check("rst_wr_en", {31'd0, wr_en_po}, 32'd0);
      check("rst_addr", {30'd0, wr_addr_po}, 32'd0);
      check("rst_data", {16'd0, wr_data_po}, 32'd0);
      check("rst_hold", {31'd0, cpu_hold_po}, 32'd0);
      check("rst_cpu_reset", {31'd0, cpu_reset_po}, 32'd0);
      check("rst_count", {29'd0, word_count_po}, 32'd0);
      check("rst_display", {16'd0, display_num_po}, 32'd0);
      reset_pi = 1'b0;
      repeat (2) tick();

      // Clean load of two words.
      load_mode_pi = 1'b1;
      start_session();
      repeat (3) tick();
      check("s1_hold_start", {31'd0, cpu_hold_po}, 32'd1);
      load_word(8'h12, 8'h34);
      check("s1_hold_mid", {31'd0, cpu_hold_po}, 32'd1);
      load_word(8'hAB, 8'hCD);
      check("s1_hold_end", {31'd0, cpu_hold_po}, 32'd1);
      check_quiet("s1");
      check("s1_count_literal", {29'd0, word_count_po}, 32'd2);
      check("s1_data_literal", {16'd0, wr_data_po}, 32'hABCD);
`ifdef LOADER_CHECKSUM_EN
      check("s1_sum_literal", {16'd0, display_num_po}, 32'hBE01);
`endif

      // Bounce rejection: one-tick glitch, then a 5-cycle hold.
      byte_pi   = 8'hEE;
      strobe_pi = 1'b1;
      tick();
      strobe_pi = 1'b0;
      repeat (10) tick();
      check("glitch_no_capture_display", {16'd0, display_num_po}, {16'd0, m_display()});
      press_byte(8'h77, 5);
`ifndef LOADER_CHECKSUM_EN
      check("waitlo_display_literal", {16'd0, display_num_po}, 32'h0277);
`endif
      push_word(16'h7788);
      press_byte(8'h88, 8);
      check_quiet("s2");

      // Exit mid-word.
      rst_snapshot = n_rst_pulse;
      wr_snapshot  = n_wr_seen;
      press_byte(8'h55, 8);
`ifndef LOADER_CHECKSUM_EN
      check("waitlo_display_55", {16'd0, display_num_po}, 32'h0355);
`endif
      load_mode_pi = 1'b0;
      repeat (4) tick();
      check("exit_reset_pulses", 32'(n_rst_pulse - rst_snapshot), 32'd1);
      check("exit_no_write", 32'(n_wr_seen - wr_snapshot), 32'd0);
      check("exit_hold", {31'd0, cpu_hold_po}, 32'd0);
      check("exit_count_held", {29'd0, word_count_po}, 32'd3);
      check("exit_data_held", {16'd0, wr_data_po}, 32'h7788);

      // Fresh session fills memory; the fifth word is dropped.
      load_mode_pi = 1'b1;
      start_session();
      repeat (3) tick();
      check_quiet("s4_start");
      load_word(8'h01, 8'h02);
      load_word(8'h03, 8'h04);
      load_word(8'h05, 8'h06);
      load_word(8'h07, 8'h08);
      check_quiet("s4_full");
      check("full_addr_literal", {30'd0, wr_addr_po}, 32'd3);
      check("full_count_literal", {29'd0, word_count_po}, 32'd4);
      wr_snapshot = n_wr_seen;
      load_word(8'h09, 8'h0A);
      check("full_no_write", 32'(n_wr_seen - wr_snapshot), 32'd0);
      check_quiet("s4_after");
      check("full_hold", {31'd0, cpu_hold_po}, 32'd1);
      rst_snapshot = n_rst_pulse;
      load_mode_pi = 1'b0;
      repeat (4) tick();
      check("full_exit_pulse", 32'(n_rst_pulse - rst_snapshot), 32'd1);

      // Reset during WRITE.
      load_mode_pi = 1'b1;
      start_session();
      repeat (3) tick();
      press_byte(8'h11, 8);
      byte_pi   = 8'h22;
      strobe_pi = 1'b1;
      seen      = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (wr_en_po) seen = 1'b1;
      end
      check("rst_write_reached", {31'd0, seen}, 32'd1);
      rst_snapshot = n_rst_pulse;
      #1;
      reset_pi = 1'b1;
      #1;
      check("midrst_wr_en_async", {31'd0, wr_en_po}, 32'd0);
      check("midrst_addr", {30'd0, wr_addr_po}, 32'd0);
      check("midrst_data", {16'd0, wr_data_po}, 32'd0);
      check("midrst_count", {29'd0, word_count_po}, 32'd0);
      check("midrst_hold", {31'd0, cpu_hold_po}, 32'd0);
      check("midrst_display", {16'd0, display_num_po}, 32'd0);
      strobe_pi    = 1'b0;
      load_mode_pi = 1'b0;
      repeat (3) tick();
      reset_pi = 1'b0;
      repeat (6) tick();
      check("midrst_no_cpu_reset", 32'(n_rst_pulse - rst_snapshot), 32'd0);
      m_last = 16'h0000;

      // Checksum wrap: 0xFFFF + 0x0002.
      load_mode_pi = 1'b1;
      start_session();
      repeat (3) tick();
      check_quiet("s6_start");
      load_word(8'hFF, 8'hFF);
      load_word(8'h00, 8'h02);
      check_quiet("s6");
`ifdef LOADER_CHECKSUM_EN
      check("checksum_literal", {16'd0, display_num_po}, 32'h0001);
`else
      check("last_word_literal", {16'd0, display_num_po}, 32'h0002);
`endif
      load_mode_pi = 1'b0;
      repeat (4) tick();
      check("idle_display_held", {16'd0, display_num_po}, {16'd0, m_display()});
      check("idle_hold", {31'd0, cpu_hold_po}, 32'd0);

      check("all_writes_seen", 32'(n_wr_seen), 32'(n_exp_writes));
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program into the writable instruction memory from the board switches and a push button, word by word, while the processor is held off. The processor reads instruction memory; this block is the writer on the same port. It sits between the board I/O (SW, BTN) and the instruction-memory write port, and drives the processor hold/restart and the seven-segment display number while loading.

## Interface

Parameters:
- ADDR_WIDTH, default 8: instruction-memory word address width; capacity is 2^ADDR_WIDTH words.
- DEBOUNCE_TICKS, default 4: number of consecutive clk_en_pi ticks a changed strobe level must hold before it is accepted.

Ports:
- clk_pi  in  1  system clock. This is the block's one clock.
- reset_pi  in  1  reset; asynchronous, active-high.
- clk_en_pi  in  1  debounce tick enable, one clk_pi cycle wide.
- load_mode_pi  in  1  level; high requests a load session (slide switch).
- byte_pi  in  8  data byte from the switches.
- strobe_pi  in  1  raw, bouncing push button.
- wr_en_po  out  1  instruction-memory write strobe, one cycle.
- wr_addr_po  out  ADDR_WIDTH  write word address.
- wr_data_po  out  16  write data.
- cpu_hold_po  out  1  high stalls the processor clock enable.
- cpu_reset_po  out  1  one-cycle processor reset pulse at the end of a session.
- word_count_po  out  ADDR_WIDTH+1  number of words written in the current or last session.
- display_num_po  out  16  value for the seven-segment display.

## Operation

Reset values:
- All outputs are 0.
- The state is IDLE.
- The debounced strobe level is 0.

Strobe conditioning:
- strobe_pi passes through a 2-flop synchronizer clocked every clk_pi cycle.
- The debounce counter advances only on clk_en_pi, and only while the synchronized level differs from the debounced level.
- The counter clears whenever the two levels agree.
- When the counter reaches DEBOUNCE_TICKS, the debounced level takes the new value and the counter clears.
- press = debounced level rose on the previous edge. It is high for exactly one clk_pi cycle.

FSM states:
- IDLE
  - cpu_hold_po is 0.
  - load_mode_pi = 1 moves to WAIT_HI. On that transition wr_addr_po, word_count_po and the checksum are cleared.
- WAIT_HI
  - press captures byte_pi into the pending high byte and moves to WAIT_LO.
- WAIT_LO
  - press registers wr_data_po = {pending_hi, byte_pi} and wr_en_po = 1, and moves to WRITE.
- WRITE (one cycle)
  - wr_en_po is high during this cycle.
  - On the exit edge: wr_addr_po increments, word_count_po increments, and wr_en_po returns to 0.
  - If wr_addr_po was 2^ADDR_WIDTH-1, go to FULL. Otherwise go to WAIT_HI.
- FULL
  - presses are ignored.
  - wr_addr_po stays at 2^ADDR_WIDTH-1 and does not wrap.
  - word_count_po = 2^ADDR_WIDTH.

Session end and hold:
- In every state except IDLE, cpu_hold_po = 1.
- load_mode_pi = 0 in WAIT_HI, WAIT_LO or FULL goes to IDLE.
  - Any pending high byte is discarded.
  - cpu_reset_po pulses high for the first cycle in IDLE.
  - cpu_hold_po falls on the same edge.
- word_count_po and wr_data_po hold their values in IDLE.

Boundary rules:
- press and load_mode_pi falling in the same cycle: the exit wins and no byte is captured.
- load_mode_pi falling during WRITE: the write completes, the counters increment, and the next state is IDLE.
- load_mode_pi re-rising while in IDLE starts a fresh session at address 0.
- reset_pi asserted mid-session: everything returns to reset values at once. wr_en_po drops asynchronously and no cpu_reset_po pulse is generated.

## Timing

- From a debounced low-byte press (press high in cycle t) to wr_en_po high in cycle t+1: one cycle.
- wr_addr_po and wr_data_po are stable while wr_en_po is high. The write is taken on the clock edge that ends cycle t+1.
- From a clean strobe_pi edge to press: 2 synchronizer cycles, plus DEBOUNCE_TICKS clk_en_pi ticks, plus 1 cycle.
- Two writes are never closer than 3 cycles apart.
- Bounces shorter than DEBOUNCE_TICKS ticks produce no press.

## Configuration

LOADER_CHECKSUM_EN:
- Defined:
  - A 16-bit running sum of every written word, modulo 2^16, is kept. It is cleared at session start.
  - In every state except IDLE, display_num_po shows the checksum.
  - In IDLE, display_num_po holds the final checksum.
- Undefined:
  - No checksum logic is built.
  - display_num_po = {wr_addr_po zero-extended to 8 bits, pending_hi} in WAIT_LO; the last written word otherwise.

## Test plan

Bench settings: DEBOUNCE_TICKS=2, clk_en_pi high every cycle.

1. Load session with clean presses: load_mode=1, press bytes 0x12, 0x34, 0xAB, 0xCD → wr_en pulses twice: addr 0 data 0x1234, then addr 1 data 0xABCD. word_count=2 and cpu_hold=1 throughout.
2. Bounce rejection: a strobe glitch of 1 cycle (1 tick) gives no capture. A 5-cycle hold gives exactly one capture.
3. Exit mid-word: after high byte 0x55, drop load_mode → no write, cpu_reset_po pulses exactly one cycle, cpu_hold=0. The next session starts at addr 0.
4. Full boundary with ADDR_WIDTH=2: write 4 words → state FULL, wr_addr=3, word_count=4. A fifth word pair produces no wr_en.
5. Reset during WRITE → wr_en drops immediately, all outputs 0, no cpu_reset_po pulse.
6. With LOADER_CHECKSUM_EN defined: write 0xFFFF and then 0x0002 → display_num_po = 0x0001.
